// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter.
// Holds the default address/data widths, the completion-counter width,
// the number of requesters and the arbiter state encoding.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W      = 16;
    localparam int NUM_REQ    = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk_i   - clock
//   clr_i   - synchronous clear (highest priority)
//   inc_i   - increment enable; the count sticks at all-ones
//   count_o - current count
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single memory port.
// Ports:
//   CLK, RST                      - clock, synchronous active-high reset
//   rX_addr/wen/ren/wdata         - requester X request, held until rX_ready
//   rX_rdata, rX_ready            - requester X response (valid for one cycle)
//   m_addr/wen/ren/wdata          - memory-side request (zero when idle)
//   m_rdata, m_ready              - memory-side response
//   rX_count                      - saturating count of completed transactions
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic              r0_wen,
    input  logic              r0_ren,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_ready,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic              r1_wen,
    input  logic              r1_ren,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_ready,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_wen,
    output logic              m_ren,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  r0_count,
    output logic [CNT_W-1:0]  r1_count
);

    arb_state_e state_q, state_d;
    logic       last_grant_q, last_grant_d;   // 1 => r1 was served most recently

    logic pend0, pend1;
    assign pend0 = r0_wen | r0_ren;
    assign pend1 = r1_wen | r1_ren;

    logic [NUM_REQ-1:0] done;
    logic [CNT_W-1:0]   cnt [NUM_REQ];

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state logic. On completion the other requester is preferred so a
    // requester streaming back-to-back cannot starve its peer; the handoff
    // happens at the completing edge, so consecutive grants have no gap.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pend0 && pend1) begin
                    state_d = last_grant_q ? ST_GRANT0 : ST_GRANT1;
                end else if (pend0) begin
                    state_d = ST_GRANT0;
                end else if (pend1) begin
                    state_d = ST_GRANT1;
                end
            end
            ST_GRANT0: begin
                if (m_ready) begin
                    last_grant_d = 1'b0;
                    if (pend1)      state_d = ST_GRANT1;
                    else if (pend0) state_d = ST_GRANT0;
                    else            state_d = ST_IDLE;
                end
            end
            ST_GRANT1: begin
                if (m_ready) begin
                    last_grant_d = 1'b1;
                    if (pend0)      state_d = ST_GRANT0;
                    else if (pend1) state_d = ST_GRANT1;
                    else            state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output muxing. Write takes precedence if a requester raises both
    // wen and ren, so m_ren is masked by wen.
    always_comb begin
        m_addr   = '0;
        m_wen    = 1'b0;
        m_ren    = 1'b0;
        m_wdata  = '0;
        r0_ready = 1'b0;
        r0_rdata = '0;
        r1_ready = 1'b0;
        r1_rdata = '0;
        unique case (state_q)
            ST_GRANT0: begin
                m_addr   = r0_addr;
                m_wen    = r0_wen;
                m_ren    = r0_ren & ~r0_wen;
                m_wdata  = r0_wdata;
                r0_ready = m_ready;
                r0_rdata = m_ready ? m_rdata : '0;
            end
            ST_GRANT1: begin
                m_addr   = r1_addr;
                m_wen    = r1_wen;
                m_ren    = r1_ren & ~r1_wen;
                m_wdata  = r1_wdata;
                r1_ready = m_ready;
                r1_rdata = m_ready ? m_rdata : '0;
            end
            default: ;
        endcase
    end

    assign done = {r1_ready, r0_ready};

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
            sat_counter #(
                .WIDTH (CNT_W)
            ) u_cnt (
                .clk_i   (CLK),
                .clr_i   (RST),
                .inc_i   (done[gi]),
                .count_o (cnt[gi])
            );
        end
    endgenerate

    assign r0_count = cnt[0];
    assign r1_count = cnt[1];

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RST;
    logic [AW-1:0] r0_addr, r1_addr, m_addr;
    logic          r0_wen, r0_ren, r1_wen, r1_ren, m_wen, m_ren;
    logic [DW-1:0] r0_wdata, r1_wdata, m_wdata, r0_rdata, r1_rdata, m_rdata;
    logic          r0_ready, r1_ready, m_ready;
    logic [15:0]   r0_count, r1_count;

    logic          sc_clr, sc_inc;
    logic [2:0]    sc_count;

    always #5 CLK = ~CLK;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .RST(RST),
        .r0_addr(r0_addr), .r0_wen(r0_wen), .r0_ren(r0_ren), .r0_wdata(r0_wdata),
        .r0_rdata(r0_rdata), .r0_ready(r0_ready),
        .r1_addr(r1_addr), .r1_wen(r1_wen), .r1_ren(r1_ren), .r1_wdata(r1_wdata),
        .r1_rdata(r1_rdata), .r1_ready(r1_ready),
        .m_addr(m_addr), .m_wen(m_wen), .m_ren(m_ren), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready),
        .r0_count(r0_count), .r1_count(r1_count)
    );

    // Narrow instance so saturation is reachable in a few cycles.
    sat_counter #(.WIDTH(3)) u_sc (
        .clk_i(CLK), .clr_i(sc_clr), .inc_i(sc_inc), .count_o(sc_count)
    );

    typedef struct {
        bit            wen;
        bit            ren;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            gap;
    } req_t;

    req_t q0[$];
    req_t q1[$];

    // Requester-side driven request
    bit            rq_wen   [2];
    bit            rq_ren   [2];
    logic [AW-1:0] rq_addr  [2];
    logic [DW-1:0] rq_wdata [2];

    assign r0_wen = rq_wen[0];   assign r1_wen = rq_wen[1];
    assign r0_ren = rq_ren[0];   assign r1_ren = rq_ren[1];
    assign r0_addr = rq_addr[0]; assign r1_addr = rq_addr[1];
    assign r0_wdata = rq_wdata[0]; assign r1_wdata = rq_wdata[1];

    // Reference model: who currently owns the memory (-1 = nobody),
    // who was served last, per-requester completions, requester-visible memory.
    int            owner;
    int            last;
    int            cnt [2];
    logic [DW-1:0] shadow [256];
    logic [DW-1:0] tb_mem [256];
    int            done_log[$];

    int  checks = 0;
    int  errors = 0;
    bit  chk_en = 0;
    int  mem_mode = -1;
    int  mem_wait = 0;
    bit  stall = 0;
    bit  force_ready = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int next_lat();
        return (mem_mode < 0) ? int'($urandom_range(0, 3)) : mem_mode;
    endfunction

    // Arbitration rules applied at each clock edge to the inputs the DUT samples.
    task automatic model_edge();
        bit p [2];
        int other;
        p[0] = rq_wen[0] | rq_ren[0];
        p[1] = rq_wen[1] | rq_ren[1];
        if (RST) begin
            owner = -1; last = 1; cnt[0] = 0; cnt[1] = 0;
        end else if (owner < 0) begin
            if (p[0] && p[1])  owner = 1 - last;
            else if (p[0])     owner = 0;
            else if (p[1])     owner = 1;
        end else if (m_ready) begin
            other = 1 - owner;
            last  = owner;
            if (p[other])      owner = other;
            else if (!p[owner]) owner = -1;
        end
    endtask

    // Memory behaviour: answers a visible request after a latency.
    task automatic mem_decide();
        m_rdata = $urandom;
        m_ready = 1'b0;
        if (force_ready) begin
            m_ready = 1'b1;
        end else if (!stall && (m_wen === 1'b1 || m_ren === 1'b1)) begin
            if (mem_wait == 0) begin
                m_ready = 1'b1;
                if (m_wen) tb_mem[m_addr] = m_wdata;
                else       m_rdata = tb_mem[m_addr];
                mem_wait = next_lat();
            end else begin
                mem_wait--;
            end
        end
    endtask

    task automatic cycle_checks();
        logic [AW-1:0] ea;
        logic          ew, er, e0, e1;
        logic [DW-1:0] ed;
        if (!chk_en) return;
        ea = '0; ew = 0; er = 0; ed = '0;
        if (owner >= 0) begin
            ea = rq_addr[owner];
            ew = rq_wen[owner];
            er = rq_ren[owner] & ~rq_wen[owner];
            ed = rq_wdata[owner];
        end
        e0 = (owner == 0) && m_ready;
        e1 = (owner == 1) && m_ready;
        check("m_addr", m_addr, ea);
        check("m_wen", m_wen, ew);
        check("m_ren", m_ren, er);
        check("m_wdata", m_wdata, ed);
        check("r0_ready", r0_ready, e0);
        check("r1_ready", r1_ready, e1);
        check("r0_rdata", r0_rdata, e0 ? m_rdata : '0);
        check("r1_rdata", r1_rdata, e1 ? m_rdata : '0);
        check("r0_count", r0_count, cnt[0]);
        check("r1_count", r1_count, cnt[1]);
    endtask

    task automatic present(input int x);
        req_t r;
        if (rq_wen[x] || rq_ren[x]) return;
        if (x == 0) begin
            if (q0.size() == 0) return;
            if (q0[0].gap > 0) begin q0[0].gap = q0[0].gap - 1; return; end
            r = q0.pop_front();
        end else begin
            if (q1.size() == 0) return;
            if (q1[0].gap > 0) begin q1[0].gap = q1[0].gap - 1; return; end
            r = q1.pop_front();
        end
        rq_wen[x] = r.wen; rq_ren[x] = r.ren;
        rq_addr[x] = r.addr; rq_wdata[x] = r.wdata;
    endtask

    // Requester behaviour: on completion, check read data, then drop or
    // immediately present the next queued request.
    task automatic react();
        for (int x = 0; x < 2; x++) begin
            if (owner == x && m_ready) begin
                if (rq_ren[x] && !rq_wen[x])
                    check(x == 0 ? "r0_read_value" : "r1_read_value",
                          x == 0 ? r0_rdata : r1_rdata, shadow[rq_addr[x]]);
                else
                    shadow[rq_addr[x]] = rq_wdata[x];
                if (cnt[x] < 65535) cnt[x]++;
                done_log.push_back(x);
                rq_wen[x] = 0; rq_ren[x] = 0;
            end
        end
        present(0);
        present(1);
    endtask

    task automatic step();
        model_edge();
        @(posedge CLK);
        #1 mem_decide();
        #1 cycle_checks();
        react();
    endtask

    task automatic run_idle(input int max_cyc);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || rq_wen[0] || rq_ren[0] ||
                rq_wen[1] || rq_ren[1]) && n < max_cyc) begin
            step();
            n++;
        end
        check("run_bound_hit", n >= max_cyc, 0);
        step();
    endtask

    task automatic do_reset();
        for (int x = 0; x < 2; x++) begin rq_wen[x] = 0; rq_ren[x] = 0; end
        q0.delete(); q1.delete();
        force_ready = 0; stall = 0;
        RST = 1;
        step();
        RST = 0;
        done_log.delete();
        mem_wait = next_lat();
    endtask

    task automatic check_alternating(input string tag, input int n);
        check({tag, "_len"}, done_log.size(), n);
        for (int i = 0; i < n && i < done_log.size(); i++)
            check(tag, done_log[i], i % 2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            w;

        for (int i = 0; i < 256; i++) begin shadow[i] = '0; tb_mem[i] = '0; end
        for (int x = 0; x < 2; x++) begin
            rq_wen[x] = 0; rq_ren[x] = 0; rq_addr[x] = '0; rq_wdata[x] = '0;
        end
        owner = -1; last = 1; cnt[0] = 0; cnt[1] = 0;
        m_ready = 0; m_rdata = '0; sc_clr = 1; sc_inc = 0;

        // Reset state
        RST = 1;
        step();
        chk_en = 1;
        step();
        RST = 0;

        // Single write, memory answers two cycles after the request shows
        do_reset();
        mem_mode = 2; mem_wait = 2;
        q0.push_back('{1'b1, 1'b0, 8'h10, 32'hDEADBEEF, 0});
        run_idle(50);
        check("single_count0", r0_count, 1);
        check("single_count1", r1_count, 0);
        check("single_mem", tb_mem[8'h10], 32'hDEADBEEF);
        check("single_log", done_log.size(), 1);

        // Contention: both read in the same cycle, r0 wins first
        do_reset();
        mem_mode = -1;
        q0.push_back('{1'b0, 1'b1, 8'($urandom), '0, 0});
        q1.push_back('{1'b0, 1'b1, 8'($urandom), '0, 0});
        run_idle(50);
        check_alternating("contention_order", 2);

        // Fairness: 8 back-to-back writes each
        do_reset();
        for (int i = 0; i < 8; i++) begin
            q0.push_back('{1'b1, 1'b0, 8'($urandom), $urandom, 0});
            q1.push_back('{1'b1, 1'b0, 8'($urandom), $urandom, 0});
        end
        run_idle(200);
        check_alternating("fair_order", 16);
        check("fair_count0", r0_count, 8);
        check("fair_count1", r1_count, 8);

        // Streaming: r0 writes 0..7, then r1 reads them back
        do_reset();
        for (int i = 0; i < 8; i++) q0.push_back('{1'b1, 1'b0, 8'(i), $urandom, 0});
        run_idle(200);
        for (int i = 0; i < 8; i++) q1.push_back('{1'b0, 1'b1, 8'(i), '0, 0});
        run_idle(200);
        check("stream_count0", r0_count, 8);
        check("stream_count1", r1_count, 8);

        // Reset while GRANT1 waits for the memory
        do_reset();
        stall = 1;
        q1.push_back('{1'b1, 1'b0, 8'h55, 32'h12345678, 0});
        repeat (4) step();
        check("midrst_granted", m_wen, 1);
        RST = 1; force_ready = 1;
        step();
        check("midrst_m_wen", m_wen, 0);
        check("midrst_r1_ready", r1_ready, 0);
        check("midrst_r1_count", r1_count, 0);
        RST = 0;
        rq_wen[1] = 0; rq_ren[1] = 0;
        step();
        check("late_ready_r1_ready", r1_ready, 0);
        check("late_ready_r1_count", r1_count, 0);
        step();
        check("late_ready_count_after", r1_count, 0);
        force_ready = 0; stall = 0;

        // wen and ren together on r1: write wins
        do_reset();
        a = 8'($urandom_range(16, 255)); d = $urandom;
        q1.push_back('{1'b1, 1'b1, a, d, 0});
        q1.push_back('{1'b0, 1'b1, a, '0, 0});
        run_idle(50);
        check("wen_ren_mem", tb_mem[a], d);
        check("wen_ren_count1", r1_count, 2);

        // Randomised traffic
        do_reset();
        for (int i = 0; i < 30; i++) begin
            w = 1'($urandom_range(0, 1));
            q0.push_back('{w, w ? 1'($urandom_range(0, 1)) : 1'b1,
                           8'($urandom_range(0, 15)), $urandom, int'($urandom_range(0, 3))});
            w = 1'($urandom_range(0, 1));
            q1.push_back('{w, w ? 1'($urandom_range(0, 1)) : 1'b1,
                           8'($urandom_range(0, 15)), $urandom, int'($urandom_range(0, 3))});
        end
        run_idle(2000);
        check("rand_count0", r0_count, 30);
        check("rand_count1", r1_count, 30);

        // Saturating counter: one below max, then two more stays at max
        sc_clr = 1;
        step();
        sc_clr = 0; sc_inc = 1;
        repeat (6) step();
        check("sat_below_max", sc_count, 6);
        repeat (2) step();
        check("sat_at_max", sc_count, 7);
        step();
        check("sat_hold", sc_count, 7);
        sc_inc = 0; sc_clr = 1;
        step();
        check("sat_clear", sc_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W SHALL default to 8 and is the address width on all ports.
REQ-002 Parameter DATA_W SHALL default to 32 and is the data width on all ports.
REQ-003 CLK  in  1  SHALL be the single clock; all state updates on posedge CLK.
REQ-004 RST  in  1  SHALL be a synchronous, active-high reset.
REQ-005 r0_addr, r1_addr  in  ADDR_W  SHALL be the requester addresses.
REQ-006 r0_wen, r1_wen  in  1  SHALL be the requester write requests.
REQ-007 r0_ren, r1_ren  in  1  SHALL be the requester read requests.
REQ-008 r0_wdata, r1_wdata  in  DATA_W  SHALL be the requester write data.
REQ-009 r0_rdata, r1_rdata  out  DATA_W  SHALL be the requester read data.
REQ-010 r0_ready, r1_ready  out  1  SHALL be the requester completion strobes.
REQ-011 m_addr  out  ADDR_W, m_wen  out  1, m_ren  out  1, m_wdata  out  DATA_W SHALL be the memory-side request.
REQ-012 m_rdata  in  DATA_W, m_ready  in  1 SHALL be the memory-side response.
REQ-013 r0_count, r1_count  out  16  SHALL be the per-requester completed-transaction counters.

Function
REQ-014 Requester x SHALL be pending when rx_wen or rx_ren is 1; the requester holds addr, wdata, wen and ren stable until rx_ready.
REQ-015 The FSM SHALL have three states: IDLE, GRANT0 and GRANT1.
REQ-016 In IDLE with exactly one requester pending, the FSM SHALL go to that requester's GRANT state at the next edge.
REQ-017 In IDLE with both pending, the FSM SHALL grant the requester not granted most recently (last_grant register, reset value 1, so r0 wins first).
REQ-018 In GRANTx, m_addr, m_wen and m_wdata SHALL combinationally equal requester x's signals, and m_ren SHALL equal rx_ren & ~rx_wen (write wins if both asserted).
REQ-019 Outside GRANT states, all m_* outputs SHALL be 0.
REQ-020 In GRANTx with m_ready=1, rx_ready SHALL be 1 for that cycle only, and rx_rdata SHALL equal m_rdata; otherwise rx_ready=0 and rx_rdata=0.
REQ-021 On m_ready in GRANTx, last_grant SHALL become x, and the next state SHALL be GRANTy if y is pending, else GRANTx if x is still pending (back-to-back new request), else IDLE.
REQ-022 Without m_ready, GRANTx SHALL hold regardless of other requests (no preemption); a requester that drops its request mid-grant is illegal and need not be handled.
REQ-023 Minimum latency SHALL be one cycle from IDLE request to memory visibility; zero-cycle handoff SHALL apply between consecutive grants.
REQ-024 rx_count SHALL increment on each rx_ready and saturate at 16'hFFFF.
REQ-025 m_ready arriving in IDLE SHALL be ignored (no ready, no count).

Reset
REQ-026 On RST=1 at posedge CLK, state SHALL become IDLE, last_grant 1, counters 0; all outputs are therefore 0 in the following cycle.
REQ-027 Reset mid-grant SHALL abandon the memory transaction; no rx_ready SHALL be issued for it.

Structure
REQ-028 Package mem_arb_pkg SHALL hold the state enum, ADDR_W/DATA_W defaults and the counter width constant (16).
REQ-029 A sub-module sat_counter (parameterised width, increment enable, synchronous clear) SHALL be instantiated once per requester; the FSM and muxing stay in mem_arbiter.

Verification
REQ-030 Single write: r0 writes addr 8'h10 with data 32'hDEADBEEF, memory ready after 2 cycles -> m_wen visible 1 cycle after request, r0_ready is a 1-cycle pulse, r0_count=1.
REQ-031 Contention: r0 and r1 request reads in the same IDLE cycle -> r0 granted first, r1 granted the cycle after r0_ready, with no IDLE gap.
REQ-032 Fairness: both requesters hold continuous back-to-back writes for 8 transactions each -> grants alternate 0,1,0,1,... and r0_count=r1_count=8.
REQ-033 Streaming: r0 alone does 8 sequential writes from 8'h00, then r1 reads them -> each read returns the data written, and r1_rdata is 0 whenever r1_ready=0.
REQ-034 Reset mid-grant: RST asserted while GRANT1 waits on m_ready -> next cycle all m_* =0, no r1_ready, counters 0; a late m_ready is ignored.
REQ-035 wen&ren on r1 together -> m_wen=1, m_ren=0; saturation: counter preloaded to 16'hFFFE via 2 extra completions past 16'hFFFF stays at 16'hFFFF.
